// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, 32-step restoring divider and data SRAM request; `EX_MUL_EN adds alu_op 13 = MUL
module ex_stage #(
    parameter int ID_TO_EX_WD  = 146,
    parameter int EX_TO_MEM_WD = 76
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);
    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    div_state_e             state_q, state_d;
    logic [ID_TO_EX_WD-1:0] id_ex_q, id_ex_d;
    logic [31:0]            rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   nq_q, nq_d, nr_q, nr_d;

    logic [31:0] pc, src1, src2, store_data, alu_res, quo_s, rem_s, ex_result;
    logic [3:0]  alu_op, wen;
    logic [1:0]  div_op;
    logic [4:0]  waddr;
    logic        ram_en, sel_rf_res, rf_we, div_pend, sgn, ge, rf_we_o, ram_en_o;
    logic [32:0] r_sh, diff;
    logic        unused_stall;

    assign {pc, alu_op, div_op, ram_en, wen, sel_rf_res, rf_we, waddr, src1, src2, store_data} = id_ex_q;
    assign unused_stall = ^{stall[5:4], stall[1:0]};

    assign sgn      = div_op == 2'b01;
    assign div_pend = sgn || div_op == 2'b10;
    assign r_sh     = {rem_q, quo_q[31]};
    assign diff     = r_sh - {1'b0, dvs_q};
    assign ge       = !diff[32];
    assign quo_s    = nq_q ? -quo_q : quo_q;
    assign rem_s    = nr_q ? -rem_q : rem_q;

    assign stallreq_for_ex = (state_q == IDLE && div_pend) || state_q == RUN;
    assign rf_we_o         = rf_we && !stallreq_for_ex;
    assign ram_en_o        = ram_en && !stallreq_for_ex;
    assign ex_result       = div_pend ? quo_s : alu_res;

    assign ex_to_mem_bus   = {pc, ram_en_o, wen, sel_rf_res, rf_we_o, waddr, ex_result};
    assign ex_to_id        = {rf_we_o, waddr, ex_result};
    assign data_sram_en    = ram_en_o;
    assign data_sram_wen   = wen;
    assign data_sram_addr  = src1 + src2;
    assign data_sram_wdata = store_data;

    // Input register: a stopped EX feeding a running MEM inserts a bubble
    always_comb begin
        id_ex_d = (stall[2] && !stall[3]) ? '0 : !stall[2] ? id_to_ex_bus : id_ex_q;
    end

    // Single-cycle ALU operations
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = src1 + src2;
            4'd1:    alu_res = src1 - src2;
            4'd2:    alu_res = src1 & src2;
            4'd3:    alu_res = src1 | src2;
            4'd4:    alu_res = src1 ^ src2;
            4'd5:    alu_res = ~(src1 | src2);
            4'd6:    alu_res = {31'b0, $signed(src1) < $signed(src2)};
            4'd7:    alu_res = {31'b0, src1 < src2};
            4'd8:    alu_res = src2 << src1[4:0];
            4'd9:    alu_res = src2 >> src1[4:0];
            4'd10:   alu_res = $signed(src2) >>> src1[4:0];
            4'd11:   alu_res = {src2[15:0], 16'b0};
            4'd12:   alu_res = hi_q;
`ifdef EX_MUL_EN
            4'd13:   alu_res = src1 * src2;
`endif
            default: alu_res = '0;
        endcase
    end

    // Divider FSM: magnitudes are divided unsigned, signs are applied when presenting the result
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: if (div_pend) begin
                if (src2 == '0) begin
                    quo_d   = '0;
                    rem_d   = src1;
                    nq_d    = 1'b0;
                    nr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    quo_d   = (sgn && src1[31]) ? -src1 : src1;
                    dvs_d   = (sgn && src2[31]) ? -src2 : src2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    nq_d    = sgn && (src1[31] ^ src2[31]);
                    nr_d    = sgn && src1[31];
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = ge ? diff[31:0] : r_sh[31:0];
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_CYCLES - 1)) state_d = DONE;
            end
            DONE: begin
                hi_d = rem_s;
                if (!stall[2]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_ex_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            id_ex_q <= id_ex_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            hi_q    <= hi_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with a stall controller that honours stallreq_for_ex
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall, stall_ext;
    logic [145:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         stallreq_for_ex;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cnt;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id(ex_to_id),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .stallreq_for_ex(stallreq_for_ex)
    );

    always #5 clk = ~clk;

    assign stall = stallreq_for_ex ? 6'b001111 : stall_ext;

    task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [145:0] mk(input logic [31:0] pc, input logic [3:0] op, input logic [1:0] dop,
                                        input logic en, input logic [3:0] wen, input logic we, input logic [4:0] wa,
                                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd);
        return {pc, op, dop, en, wen, 1'b0, we, wa, s1, s2, sd};
    endfunction

    task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
        id_to_ex_bus = mk(32'h200, op, 2'b00, 1'b0, 4'h0, 1'b1, 5'd2, a, b, 32'h0);
        tick();
        check(tag, {44'h0, ex_to_id[31:0]}, {44'h0, r});
    endtask

    task automatic count_stall();
        cnt = 0;
        while (stallreq_for_ex && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_ext = 6'h0;
        id_to_ex_bus = mk(32'hABCD, 4'd0, 2'b00, 1'b1, 4'hF, 1'b1, 5'd9, 32'h1, 32'h2, 32'h3);
        tick();
        tick();
        check("rst_mem_bus", ex_to_mem_bus, 76'h0);
        check("rst_to_id", {38'h0, ex_to_id}, 76'h0);
        check("rst_stallreq", {75'h0, stallreq_for_ex}, 76'h0);
        check("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'h0);
        rst = 1'b0;

        id_to_ex_bus = mk(32'h100, 4'd0, 2'b00, 1'b0, 4'h0, 1'b1, 5'd5, 32'h7FFFFFFF, 32'h1, 32'h0);
        tick();
        check("add_to_id", {38'h0, ex_to_id}, {38'h0, 1'b1, 5'd5, 32'h80000000});
        check("add_mem_bus", ex_to_mem_bus, {32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h80000000});

        alu("sub", 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE);
        alu("and", 4'd2, 32'hF0F0, 32'hFF00, 32'hF000);
        alu("nor", 4'd5, 32'h0, 32'h0, 32'hFFFFFFFF);
        alu("slt", 4'd6, 32'hFFFFFFFF, 32'h1, 32'h1);
        alu("sltu", 4'd7, 32'hFFFFFFFF, 32'h1, 32'h0);
        alu("sll", 4'd8, 32'd31, 32'h1, 32'h80000000);
        alu("srl", 4'd9, 32'd36, 32'hF0, 32'h0F);
        alu("sra", 4'd10, 32'd4, 32'h80000000, 32'hF8000000);
        alu("lui", 4'd11, 32'h0, 32'hFFFF1234, 32'h12340000);
        alu("op14", 4'd14, 32'h5, 32'h6, 32'h0);
`ifndef EX_MUL_EN
        alu("op13", 4'd13, 32'h5, 32'h6, 32'h0);
`else
        alu("mul", 4'd13, 32'h5, 32'h6, 32'h1E);
`endif

        id_to_ex_bus = mk(32'h300, 4'd0, 2'b00, 1'b1, 4'hF, 1'b0, 5'd0, 32'h1000, 32'h10, 32'hDEADBEEF);
        tick();
        check("store_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              {1'b1, 4'hF, 32'h1010, 32'hDEADBEEF});

        id_to_ex_bus = mk(32'h400, 4'd0, 2'b01, 1'b0, 4'h0, 1'b1, 5'd3, 32'hFFFFFFF9, 32'd2, 32'h0);
        tick();
        check("div_we_masked", {75'h0, ex_to_id[37]}, 76'h0);
        count_stall();
        check("div_stall_cycles", 76'(cnt), 76'd33);
        check("div_quot", {38'h0, ex_to_id}, {38'h0, 1'b1, 5'd3, 32'hFFFFFFFD});
        id_to_ex_bus = mk(32'h404, 4'd12, 2'b00, 1'b0, 4'h0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        tick();
        check("div_hi", {44'h0, ex_to_id[31:0]}, {44'h0, 32'hFFFFFFFF});

        id_to_ex_bus = mk(32'h500, 4'd0, 2'b10, 1'b0, 4'h0, 1'b1, 5'd6, 32'd100, 32'd0, 32'h0);
        tick();
        count_stall();
        check("divu0_stall_cycles", 76'(cnt), 76'd1);
        check("divu0_quot", {44'h0, ex_to_id[31:0]}, 76'h0);
        id_to_ex_bus = mk(32'h504, 4'd12, 2'b00, 1'b0, 4'h0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        tick();
        check("divu0_hi", {44'h0, ex_to_id[31:0]}, 76'd100);

        id_to_ex_bus = mk(32'h600, 4'd0, 2'b00, 1'b0, 4'h0, 1'b1, 5'd7, 32'd1, 32'd2, 32'h0);
        tick();
        stall_ext = 6'b000100;
        id_to_ex_bus = mk(32'h604, 4'd0, 2'b00, 1'b1, 4'h3, 1'b1, 5'd8, 32'd5, 32'd5, 32'h0);
        tick();
        check("bubble", ex_to_mem_bus, 76'h0);
        check("bubble_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'h0);
        stall_ext = 6'b000000;
        id_to_ex_bus = mk(32'h600, 4'd0, 2'b00, 1'b0, 4'h0, 1'b1, 5'd7, 32'd1, 32'd2, 32'h0);
        tick();
        stall_ext = 6'b001100;
        id_to_ex_bus = mk(32'h604, 4'd0, 2'b00, 1'b1, 4'h3, 1'b1, 5'd8, 32'd5, 32'd5, 32'h0);
        tick();
        check("hold", ex_to_mem_bus, {32'h600, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'd3});
        stall_ext = 6'b000000;

        id_to_ex_bus = mk(32'h700, 4'd0, 2'b01, 1'b1, 4'hF, 1'b1, 5'd9, 32'd100, 32'd7, 32'h0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("run_stallreq", {75'h0, stallreq_for_ex}, 76'h1);
        check("run_sram_masked", {75'h0, data_sram_en}, 76'h0);
        rst = 1'b1;
        tick();
        check("abort_stallreq", {75'h0, stallreq_for_ex}, 76'h0);
        check("abort_mem_bus", ex_to_mem_bus, 76'h0);
        check("abort_to_id", {38'h0, ex_to_id}, 76'h0);
        rst = 1'b0;
        id_to_ex_bus = mk(32'h704, 4'd12, 2'b00, 1'b0, 4'h0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h0);
        tick();
        check("abort_hi", {44'h0, ex_to_id[31:0]}, 76'h0);
        check("abort_idle", {75'h0, stallreq_for_ex}, 76'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; sits directly upstream of the memory stage.
- Registers the decoded bus from decode under stall control. Computes the ALU result, or runs a 32-cycle iterative divider that requests a pipeline stall.
- Drives the data SRAM request and produces the 76-bit EX→MEM bus and the 38-bit EX→ID forwarding bus.

Parameters:
- ID_TO_EX_WD, 146, decode→execute bus width.
- EX_TO_MEM_WD, 76, execute→memory bus width.
- DIV_CYCLES, 32, divider iteration count (fixed; not to be overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  6  pipeline stall bus; bit 2 = EX input register, bit 3 = MEM input register; 1 = Stop
- id_to_ex_bus  in  146  {pc[145:114], alu_op[113:110], div_op[109:108], data_ram_en[107], data_ram_wen[106:103], sel_rf_res[102], rf_we[101], rf_waddr[100:96], src1[95:64], src2[63:32], store_data[31:0]}
- ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_to_id  out  38  {rf_we, rf_waddr, ex_result}
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  address = src1+src2
- data_sram_wdata  out  32  store_data
- stallreq_for_ex  out  1  divider busy; the controller stops stall[0..3]

Behaviour:
- Input register, in priority order:
  - rst → 0.
  - stall[2]=Stop and stall[3]=NoStop → 0 (bubble).
  - stall[2]=NoStop → load id_to_ex_bus.
  - Otherwise hold.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU.
  - 8 SLL src2<<src1[4:0], 9 SRL, 10 SRA.
  - 11 LUI {src2[15:0],16'b0}, 12 MFHI (hi register).
  - 13–15 → 0.
  - All arithmetic is modulo 2^32; no overflow trap.
- div_op encoding: 00 none, 01 DIV signed, 10 DIVU, 11 treated as none.
  - When div_op≠0, ex_result = quotient and the remainder is written to hi.
- Divider FSM, states IDLE, RUN, DONE:
  - IDLE with div_op≠0 held: latch |dividend| and |divisor| (raw values for DIVU), counter=0, go to RUN.
  - RUN: one restoring shift-subtract step per cycle. After 32 steps go to DONE.
  - DONE: apply signs (quotient negative iff operand signs differ; remainder takes the dividend's sign). Write hi, present quotient on ex_result, return to IDLE on the next cycle.
  - Divisor = 0: IDLE goes directly to DONE; quotient 0, remainder = dividend. This is 1 stall cycle.
- stallreq_for_ex = 1 in IDLE with a div pending and throughout RUN; 0 in DONE.
  - Normal divide: 33 stall cycles; the result leaves on the DONE cycle.
  - While stallreq_for_ex=1: rf_we, data_ram_en and data_sram_en are forced to 0 on all outputs.
- DONE exits only when stall[2]=NoStop. If an external stall holds EX in DONE, the result is held and the divide is not restarted.
- Memory request: data_sram_en = data_ram_en and not stallreq_for_ex; wen passes through.
- ex_to_id mirrors the rf_we, rf_waddr and ex_result fields of ex_to_mem_bus.
- Reset values: all outputs 0, FSM IDLE, hi=0.
  - Reset mid-divide aborts the divide; hi is not updated.
- An input-register bubble (all-zero bus) produces all-zero outputs, since ADD 0+0 = 0.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: alu_op 13 = MUL, low 32 bits of src1*src2, single cycle, no stall.
- Undefined: alu_op 13 → 0 and no multiplier is inferred.

Test Plan:
- ADD src1=0x7FFFFFFF src2=1, rf_we=1, waddr=5 → ex_result=0x80000000; ex_to_id={1,5,0x80000000} one cycle after load.
- Store: data_ram_en=1, wen=4'hF, src1=0x1000, src2=0x10, store_data=0xDEADBEEF → sram_en=1, addr=0x1010, wdata=0xDEADBEEF.
- DIV −7 / 2 → stallreq high for exactly 33 cycles; then ex_result=0xFFFFFFFD (−3) and MFHI returns 0xFFFFFFFF (−1).
- DIVU 100 / 0 → 1 stall cycle; quotient 0; hi=100.
- stall[2]=Stop with stall[3]=NoStop → next ex_to_mem_bus=0; stall[2]=Stop with stall[3]=Stop → register held.
- rst asserted at RUN step 10 → next cycle FSM IDLE, stallreq=0, all outputs 0, hi unchanged from 0.
